// File: rtl/alu_sequencer.sv
// alu_sequencer: drives the shared 16-bit Hack ALU for one request at a time
// and returns result plus zr/ng/err flags over a valid/ready response channel.
// Ports: clk, rst_n; req_valid/req_ready/req_op/req_a/req_b;
//        resp_valid/resp_ready/resp_data/resp_zr/resp_ng/resp_err;
//        alu_zx..alu_no, alu_x, alu_y (to ALU), alu_out (from ALU).
// Macro ALU_SEQ_MUL_EN: opcode 15 becomes a 16-cycle shift-add multiply.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_zr,
    output logic        resp_ng,
    output logic        resp_err,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    input  logic [15:0] alu_out
);

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, DONE, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

    state_t      state;
    logic [5:0]  alu_ctl;
    logic [5:0]  dec_ctl;
    logic        dec_legal;
    logic [15:0] res;
    logic        err;
`ifdef ALU_SEQ_MUL_EN
    logic [15:0] q;
    logic [3:0]  cnt;
`endif

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctl;

    always_comb begin
        dec_ctl   = 6'b000000;
        dec_legal = 1'b1;
        case (req_op)
            4'd0:    dec_ctl = 6'b101010;
            4'd1:    dec_ctl = 6'b111111;
            4'd2:    dec_ctl = 6'b111010;
            4'd3:    dec_ctl = 6'b001100;
            4'd4:    dec_ctl = 6'b110000;
            4'd5:    dec_ctl = 6'b001101;
            4'd6:    dec_ctl = 6'b001111;
            4'd7:    dec_ctl = 6'b011111;
            4'd8:    dec_ctl = 6'b001110;
            4'd9:    dec_ctl = 6'b000010;
            4'd10:   dec_ctl = 6'b010011;
            4'd11:   dec_ctl = 6'b000000;
            4'd12:   dec_ctl = 6'b010101;
            default: dec_legal = 1'b0;
        endcase
    end

    // During MUL, alu_x is the accumulator and alu_y the shifted multiplicand,
    // so the ALU operand registers double as the multiply state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= 16'd0;
            resp_zr    <= 1'b0;
            resp_ng    <= 1'b0;
            resp_err   <= 1'b0;
            alu_ctl    <= 6'd0;
            alu_x      <= 16'd0;
            alu_y      <= 16'd0;
            res        <= 16'd0;
            err        <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            q          <= 16'd0;
            cnt        <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        if (req_op == 4'd15) begin
                            state   <= MUL;
                            alu_ctl <= 6'b000010;
                            alu_x   <= 16'd0;
                            alu_y   <= req_a;
                            q       <= req_b;
                            cnt     <= 4'd0;
                        end else
`endif
                        if (dec_legal) begin
                            state   <= EXEC;
                            alu_ctl <= dec_ctl;
                            alu_x   <= req_a;
                            alu_y   <= req_b;
                        end else begin
                            state <= DONE;
                            res   <= 16'd0;
                            err   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    res     <= alu_out;
                    err     <= 1'b0;
                    alu_ctl <= 6'd0;
                    alu_x   <= 16'd0;
                    alu_y   <= 16'd0;
                    state   <= DONE;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (q[0]) alu_x <= alu_out;
                    alu_y <= alu_y << 1;
                    q     <= q >> 1;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        res     <= q[0] ? alu_out : alu_x;
                        err     <= 1'b0;
                        alu_ctl <= 6'd0;
                        alu_x   <= 16'd0;
                        alu_y   <= 16'd0;
                        state   <= DONE;
                    end
                end
`endif
                DONE: begin
                    // First DONE cycle publishes the payload; it then
                    // stays frozen until the consumer takes it.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= res;
                        resp_zr    <= (res == 16'd0);
                        resp_ng    <= res[15];
                        resp_err   <= err;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_data  <= 16'd0;
                        resp_zr    <= 1'b0;
                        resp_ng    <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
